// File: rtl/bike_threshold_ctrl_if.sv
// Bundle of the request/result handshake and the multiply-add operand/product bus
// between the BIKE threshold controller, the DSP stage and the decoder control.
interface bike_threshold_ctrl_if #(
    parameter int WEIGHT_W = 15,
    parameter int TH_W     = 8
);
    logic                start;
    logic [WEIGHT_W-1:0] weight;
    logic                busy;
    logic                mul_en;
    logic [24:0]         mul_a;
    logic [17:0]         mul_b;
    logic [47:0]         mul_c;
    logic [47:0]         mul_p;
    logic                th_valid;
    logic [TH_W-1:0]     th;

    // Controller side: receives requests and products, drives operands and results.
    modport slave (
        input  start,
        input  weight,
        input  mul_p,
        output busy,
        output mul_en,
        output mul_a,
        output mul_b,
        output mul_c,
        output th_valid,
        output th
    );

    // Environment side: decoder control plus the multiply-add stage.
    modport master (
        output start,
        output weight,
        output mul_p,
        input  busy,
        input  mul_en,
        input  mul_a,
        input  mul_b,
        input  mul_c,
        input  th_valid,
        input  th
    );
endinterface

// File: rtl/bike_threshold_ctrl.sv
// BIKE bit-flipping threshold controller: th = max(floor(COEFF*|s| + OFFSET), TH_MIN).
// The multiply-add itself lives in an external DSP stage; this block sequences it
// (IDLE -> MUL -> EVAL), then truncates, saturates and clamps its registered P output.
module bike_threshold_ctrl #(
    parameter int          WEIGHT_W  = 15,
    parameter int          FRAC_BITS = 24,
    parameter logic [17:0] COEFF     = 18'd116974,
    parameter logic [47:0] OFFSET    = 48'd226995732,
    parameter int          TH_W      = 8,
    parameter int          TH_MIN    = 36
) (
    input  logic                   clk,
    input  logic                   resetn,
    bike_threshold_ctrl_if.slave   bus
);

    // Integer part of the fixed-point product-sum.
    localparam int INT_W = 48 - FRAC_BITS;
    localparam logic [INT_W-1:0] L_TH_MAX = {{(INT_W-TH_W){1'b0}}, {TH_W{1'b1}}};
    localparam logic [TH_W-1:0]  L_TH_MIN = TH_W'(TH_MIN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_EVAL = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_busy;
    logic                w_mul_en;
    logic [WEIGHT_W-1:0] r_weight;
    logic [TH_W-1:0]     r_th;
    logic                r_th_valid;
    logic [INT_W-1:0]    w_int;
    logic [TH_W-1:0]     w_sat;
    logic [TH_W-1:0]     w_th_next;

    // State register; reset abandons any in-flight computation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: MUL and EVAL each last exactly one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_MUL;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_MUL:   w_next_state = S_EVAL;
            S_EVAL:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs: busy outside IDLE, DSP clock enable only in MUL.
    always_comb begin
        w_busy   = 1'b0;
        w_mul_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy   = 1'b0;
                w_mul_en = 1'b0;
            end
            S_MUL: begin
                w_busy   = 1'b1;
                w_mul_en = 1'b1;
            end
            S_EVAL: begin
                w_busy   = 1'b1;
                w_mul_en = 1'b0;
            end
            default: begin
                w_busy   = 1'b0;
                w_mul_en = 1'b0;
            end
        endcase
    end

    // Capture the syndrome weight only when a request is accepted in IDLE,
    // so the A operand stays stable through MUL and busy-time starts are ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_weight <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_weight <= bus.weight;
        end else begin
            r_weight <= r_weight;
        end
    end

    // Floor by dropping fractional bits, saturate to TH_W bits, clamp to TH_MIN.
    always_comb begin
        w_int = bus.mul_p[47:FRAC_BITS];
        if (w_int > L_TH_MAX) begin
            w_sat = {TH_W{1'b1}};
        end else begin
            w_sat = w_int[TH_W-1:0];
        end
        if (w_sat < L_TH_MIN) begin
            w_th_next = L_TH_MIN;
        end else begin
            w_th_next = w_sat;
        end
    end

    // Result register: threshold held between updates, valid pulse for one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_th       <= '0;
            r_th_valid <= 1'b0;
        end else if (r_state == S_EVAL) begin
            r_th       <= w_th_next;
            r_th_valid <= 1'b1;
        end else begin
            r_th       <= r_th;
            r_th_valid <= 1'b0;
        end
    end

    assign bus.busy     = w_busy;
    assign bus.mul_en   = w_mul_en;
    assign bus.mul_a    = {{(25-WEIGHT_W){1'b0}}, r_weight};
    assign bus.mul_b    = COEFF;
    assign bus.mul_c    = OFFSET;
    assign bus.th       = r_th;
    assign bus.th_valid = r_th_valid;

endmodule
